sc_backg_scroll_timer: RTL and testbench

- Upstream pacing stage for the background scroll state machine: generates the active-low one-cycle scroll tick T0 that the background FSM consumes to issue its load pulse.
- Divides CLOCK_50 by a level-dependent reload value, so scrolling speeds up automatically as play continues.
- Supports pause and a crash penalty that resets speed and suppresses ticks for a hold period.

---
 rtl/sc_backg_pkg.sv | 19 +
 rtl/sc_backg_reload_counter.sv | 30 +++
 rtl/sc_backg_scroll_timer.sv | 128 ++++++++++++
 tb/tb_sc_backg_scroll_timer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_backg_pkg.sv
// Shared state encodings and default sizing for the background scroll timer.
package sc_backg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_CRASH = 2'd3
  } state_e;

  localparam int DIV_BASE_DEF        = 12500000;
  localparam int DIV_STEP_DEF        = 1250000;
  localparam int LEVELS_DEF          = 8;
  localparam int TICKS_PER_LEVEL_DEF = 16;
  localparam int CRASH_HOLD_DEF      = 4;
  localparam int CNT_W_DEF           = 24;
  localparam int LEVEL_W_DEF         = $clog2(LEVELS_DEF);

endpackage

// File: rtl/sc_backg_reload_counter.sv
// Loadable down-counter with a zero flag; load wins over enable, value changes one clock after request.
// No backpressure: it counts whenever enabled and simply holds when not.
module sc_backg_reload_counter
  import sc_backg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic             SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sc_backg_scroll_timer.sv
// Scroll pacing timer: one-cycle active-low T0 every reload(level) clocks, T0 registered one clock after expiry.
// No backpressure; pause freezes the period and a crash drops to level 0 and suppresses ticks for a hold time.
module sc_backg_scroll_timer
  import sc_backg_pkg::*;
#(
  parameter int DIV_BASE        = DIV_BASE_DEF,
  parameter int DIV_STEP        = DIV_STEP_DEF,
  parameter int LEVELS          = LEVELS_DEF,
  parameter int TICKS_PER_LEVEL = TICKS_PER_LEVEL_DEF,
  parameter int CRASH_HOLD      = CRASH_HOLD_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int LEVEL_W         = LEVEL_W_DEF
) (
  input  logic               SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic               SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic               start_InLow,
  input  logic               pause_InLow,
  input  logic               crash_InLow,
  output logic               T0_OutLow,
  output logic [LEVEL_W-1:0] level_Out,
  output logic               running_OutHigh
);

  localparam int TICK_W = $clog2(TICKS_PER_LEVEL + 1);
  localparam int HOLD_W = $clog2(CRASH_HOLD + 1);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               t0_q, t0_d;
  logic               running_q;
  logic               cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]   reload_m1;

  // Crash forces level 0, so reload(level_d) also yields the base period for every crash load.
  assign reload_m1 = CNT_W'(DIV_BASE) - CNT_W'(level_d) * CNT_W'(DIV_STEP) - CNT_W'(1);

  sc_backg_reload_counter #(.CNT_W(CNT_W)) u_cnt (
    .SC_STATEMACHINEBACKG_CLOCK_50     (SC_STATEMACHINEBACKG_CLOCK_50),
    .SC_STATEMACHINEBACKG_RESET_InHigh (SC_STATEMACHINEBACKG_RESET_InHigh),
    .load_i                            (cnt_load),
    .load_val_i                        (reload_m1),
    .en_i                              (cnt_en),
    .zero_o                            (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    tick_d   = tick_q;
    hold_d   = hold_q;
    t0_d     = 1'b1;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!start_InLow) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (!crash_InLow) begin
          state_d  = ST_CRASH;
          level_d  = '0;
          tick_d   = '0;
          hold_d   = '0;
          cnt_load = 1'b1;
        end else if (!pause_InLow && (state_q == ST_PAUSE || !cnt_zero)) begin
          state_d = ST_PAUSE;
        end else begin
          // Pause coincident with expiry still ticks and reloads before freezing.
          state_d = pause_InLow ? ST_RUN : ST_PAUSE;
          if (cnt_zero) begin
            t0_d     = 1'b0;
            cnt_load = 1'b1;
            if (tick_q == TICK_W'(TICKS_PER_LEVEL - 1)) begin
              tick_d = '0;
              if (level_q != LEVEL_W'(LEVELS - 1)) level_d = level_q + LEVEL_W'(1);
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_CRASH: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (hold_q == HOLD_W'(CRASH_HOLD - 1)) begin
            hold_d = '0;
            if (crash_InLow) state_d = ST_RUN;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      tick_q    <= '0;
      hold_q    <= '0;
      t0_q      <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      t0_q      <= t0_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign T0_OutLow       = t0_q;
  assign level_Out       = level_q;
  assign running_OutHigh = running_q;

endmodule

// File: tb/tb_sc_backg_scroll_timer.sv
// Directed plus random stimulus against a timestamp-based model of the scroll timer.
module tb_sc_backg_scroll_timer;

  localparam int DIV_BASE   = 20;
  localparam int DIV_STEP   = 4;
  localparam int LEVELS     = 4;
  localparam int TPL        = 3;
  localparam int CRASH_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_n = 1'b1, pause_n = 1'b1, crash_n = 1'b1;
  logic       t0_n;
  logic [1:0] level;
  logic       running;

  always #5 clk = ~clk;

  sc_backg_scroll_timer #(
    .DIV_BASE(DIV_BASE), .DIV_STEP(DIV_STEP), .LEVELS(LEVELS),
    .TICKS_PER_LEVEL(TPL), .CRASH_HOLD(CRASH_HOLD), .CNT_W(8), .LEVEL_W(2)
  ) dut (
    .SC_STATEMACHINEBACKG_CLOCK_50     (clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh (rst),
    .start_InLow                       (start_n),
    .pause_InLow                       (pause_n),
    .crash_InLow                       (crash_n),
    .T0_OutLow                         (t0_n),
    .level_Out                         (level),
    .running_OutHigh                   (running)
  );

  int checks = 0;
  int errors = 0;

  // Model: absolute edge timestamps for the next expiry / end of crash hold.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_CRASH = 3;
  int m_mode, m_due, m_lvl, m_ticks, m_crash_end, m_k;
  bit exp_t0;

  function automatic int reload(input int l);
    return DIV_BASE - l * DIV_STEP;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_lvl = 0; m_ticks = 0; exp_t0 = 1'b1;
  endtask

  task automatic model_crash();
    m_mode = M_CRASH; m_lvl = 0; m_ticks = 0;
    m_crash_end = m_k + CRASH_HOLD * DIV_BASE;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit c);
    m_k++;
    exp_t0 = 1'b1;
    case (m_mode)
      M_IDLE: if (!s) begin m_mode = M_RUN; m_due = m_k + reload(m_lvl); end
      M_RUN, M_PAUSE: begin
        if (!c) model_crash();
        else if (!p && (m_mode == M_PAUSE || m_k != m_due)) begin
          m_mode = M_PAUSE;
          m_due++;
        end else begin
          if (m_k == m_due) begin
            exp_t0 = 1'b0;
            m_ticks++;
            if (m_ticks == TPL) begin
              m_ticks = 0;
              if (m_lvl < LEVELS - 1) m_lvl++;
            end
            m_due = m_k + reload(m_lvl);
          end
          m_mode = p ? M_RUN : M_PAUSE;
        end
      end
      default: if (m_k == m_crash_end) begin
        if (!c) model_crash();
        else begin m_mode = M_RUN; m_due = m_k + DIV_BASE; end
      end
    endcase
  endtask

  task automatic compare_all();
    check("t0", t0_n, exp_t0);
    check("level", level, m_lvl);
    check("running", running, m_mode == M_RUN);
  endtask

  task automatic step(input bit s, input bit p, input bit c);
    start_n = s; pause_n = p; crash_n = c;
    @(posedge clk);
    model_edge(s, p, c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_until_tick(input string tag, input int expect_n);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < expect_n + 100) begin
      step(1, 1, 1);
      n++;
      if (t0_n === 1'b0) seen = 1'b1;
    end
    check(tag, n, expect_n);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_t0", t0_n, 1);
    check("arst_level", level, 0);
    check("arst_running", running, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int per_a[6]  = '{20, 20, 20, 16, 16, 16};
  int per_b[13] = '{20, 20, 20, 16, 16, 16, 12, 12, 12, 8, 8, 8, 8};

  initial begin
    m_k = 0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("rst_t0", t0_n, 1);
    check("rst_level", level, 0);
    check("rst_running", running, 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores pause and crash
    step(1, 0, 0); step(1, 1, 1); step(1, 0, 1);
    step(0, 1, 1);
    check("start_running", running, 1);
    foreach (per_a[i]) run_until_tick("period_a", per_a[i]);
    check("level_after6", level, 2);

    // pause for 5 cycles with the count at 10
    step(1, 1, 1);
    repeat (5) step(1, 0, 1);
    run_until_tick("pause_delay", 11);
    check("level_after_pause", level, 2);

    // crash at level 2
    step(1, 1, 0);
    check("crash_level", level, 0);
    run_until_tick("crash_hold", 60);
    run_until_tick("post_crash_period", 20);

    // crash exactly on the expiry edge
    repeat (19) step(1, 1, 1);
    step(1, 1, 0);
    check("crash_on_expiry_t0", t0_n, 1);
    run_until_tick("crash_on_expiry_hold", 60);

    // pause exactly on the expiry edge
    repeat (19) step(1, 1, 1);
    step(1, 0, 1);
    check("pause_on_expiry_t0", t0_n, 0);
    check("pause_on_expiry_run", running, 0);
    repeat (3) step(1, 0, 1);
    run_until_tick("pause_on_expiry_next", 20);
    check("level_after_e", level, 1);

    // asynchronous reset while T0 is low mid-run
    async_reset();
    repeat (25) step(1, 1, 1);
    check("idle_after_rst", running, 0);
    step(0, 1, 1);
    foreach (per_b[i]) run_until_tick("period_b", per_b[i]);
    check("level_saturated", level, 3);

    for (int i = 0; i < 1500; i++) begin
      bit s, p, c;
      s = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 11) != 0);
      c = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        step(s, p, c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
